usec_delay_arbiter: RTL
=======================

// Module: usec_delay_arbiter
//
// PURPOSE
//   Shares one microsecond delay timer among NUM_REQ requesters, such as the dealer-draw pause,
//   the result-display hold and the LED blink. Each request is a delay length in microseconds.
//   A round-robin arbiter picks one requester at a time. An internal prescaler makes the
//   microsecond tick, and the timer counts the granted delay down. When the delay ends, the
//   owner gets a one-cycle done pulse. Sits between the game FSMs and the system clock domain.
//
// PARAMETERS
//   NUM_REQ   4    number of requesters (2..8)
//   DUR_W     16   width of each requested duration, in microseconds
//   CLK_MHZ   50   clk frequency in MHz; one microsecond tick = CLK_MHZ clk cycles
//
// PORTS
//   clk          in   1              system clock; all logic is on the posedge
//   rst          in   1              reset, asynchronous and active-low
//   req          in   NUM_REQ        level request per requester; hold high until done or abort
//   dur          in   NUM_REQ*DUR_W  duration for requester i is dur[i*DUR_W +: DUR_W]; sampled at grant
//   busy         out  1              timer owned, i.e. state is not IDLE
//   grant_id     out  clog2(NUM_REQ) index of the current or last owner
//   done         out  NUM_REQ        one-cycle pulse to the owner when its delay expires
//   remaining_us out  DUR_W          whole microseconds left for the current owner
//
// BEHAVIOUR
//   Clock and reset
//   - One clock. Reset is asynchronous and active-low.
//   - While rst=0: state=IDLE, busy=0, grant_id=0, done=0, remaining_us=0, prescaler=0,
//     rr pointer=NUM_REQ-1 (so requester 0 has top priority first).
//   FSM: IDLE -> LOAD -> COUNT -> DONE -> IDLE
//   - IDLE: if |req, grant the first set bit searching upward from rr pointer+1, with wrap.
//     Latch dur[grant] into remaining_us and set grant_id. Next state is LOAD.
//   - LOAD (1 cycle): clear the prescaler. Go to DONE if remaining_us==0, else to COUNT.
//   - COUNT: prescaler counts 0..CLK_MHZ-1, then wraps to 0. On a wrap, remaining_us decrements.
//     A wrap while remaining_us==1 moves to DONE, with remaining_us reaching 0.
//   - DONE (1 cycle): done[grant_id]=1 and all other done bits are 0. The rr pointer is set to
//     grant_id. Next state is IDLE.
//   - busy=1 in LOAD, COUNT and DONE.
//   Latency
//   - With req high in IDLE at cycle t: LOAD at t+1, COUNT at t+2.
//   - done is high at cycle t+2+dur*CLK_MHZ. For dur=0, done is high at t+2.
//   Abort
//   - If req[grant_id] is 0 in LOAD or COUNT, go to IDLE next cycle with no done pulse.
//   - remaining_us is cleared and the rr pointer is set to grant_id.
//   Other rules
//   - Requests that arrive while busy wait; there is no queue beyond the level req.
//   - After DONE or an abort, the served requester has the lowest priority. If it holds req
//     high, it is re-granted only when no other req is set, and it re-latches its dur.
//   - dur of a non-owner may change at any time. dur of the owner is ignored after the grant.
//   - The prescaler is CLK_MHZ-wide-safe, at least clog2(CLK_MHZ) bits. There are no
//     free-running counters, so nothing wraps beyond remaining_us reaching 0.
//   - A reset during COUNT aborts immediately. No done is issued after the reset is released.
//
// TESTING (CLK_MHZ=50)
//   1. req[0]=1, dur0=3 from reset -> busy rises at t+1; done[0] pulses exactly at t+152;
//      remaining_us steps 3,2,1,0.
//   2. req[2]=1 with dur2=0 -> done[2] at t+2; busy low at t+3.
//   3. req=4'b1111 with all durs=1, each requester dropping req after its done ->
//      grants go 0,1,2,3 in order, every done 50 cycles plus overhead apart.
//   4. req[1] holds high with req[3] also pending -> after done[1], requester 3 is granted
//      before requester 1 again.
//   5. req[0] deasserted mid-COUNT (dur0=10) -> IDLE next cycle, no done, busy=0,
//      and a pending req[1] is granted the following cycle.
//   6. rst pulled low mid-COUNT -> all outputs return to reset values asynchronously,
//      and no done pulse follows the release of reset.

Source files
------------

// File: rtl/usec_delay_arbiter.sv
// Purpose: round-robin share of one microsecond delay timer among NUM_REQ requesters.
// Latency: grant->LOAD 1 cycle, done pulse at t+2+dur*CLK_MHZ (t+2 for dur=0).
// Backpressure: requests that arrive while busy wait on their level req; no queue beyond that.
module usec_delay_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DUR_W   = 16,
    parameter int CLK_MHZ = 50
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*DUR_W-1:0]   dur,
    output logic                       busy,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic [NUM_REQ-1:0]         done,
    output logic [DUR_W-1:0]           remaining_us
);

    localparam int ID_W = $clog2(NUM_REQ);
    localparam int PS_W = (CLK_MHZ > 1) ? $clog2(CLK_MHZ) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(CLK_MHZ - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        COUNT = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ID_W-1:0]   rr_ptr;
    logic [ID_W-1:0]   rr_nxt;
    logic [ID_W-1:0]   gid_nxt;
    logic [PS_W-1:0]   ps;
    logic [PS_W-1:0]   ps_nxt;
    logic [DUR_W-1:0]  rem_nxt;
    logic [DUR_W-1:0]  durs [NUM_REQ];
    logic [ID_W-1:0]   hi_pick;
    logic [ID_W-1:0]   lo_pick;
    logic              hi_vld;
    logic [ID_W-1:0]   pick;
    logic              owner_req;

    // Unpack the flat duration bus into one entry per requester.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            durs[i] = dur[i*DUR_W +: DUR_W];
        end
    end

    // Round-robin pick: lowest requester above rr_ptr, else lowest overall (the wrap).
    always_comb begin
        hi_vld  = 1'b0;
        hi_pick = '0;
        lo_pick = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[i] && (ID_W'(i) > rr_ptr)) begin
                hi_vld  = 1'b1;
                hi_pick = ID_W'(i);
            end
            if (req[i]) begin
                lo_pick = ID_W'(i);
            end
        end
        pick = hi_vld ? hi_pick : lo_pick;
    end

    // Next-state and datapath update; an owner dropping req always wins over expiry.
    always_comb begin
        state_nxt = state;
        rem_nxt   = remaining_us;
        ps_nxt    = ps;
        gid_nxt   = grant_id;
        rr_nxt    = rr_ptr;
        owner_req = req[grant_id];
        case (state)
            IDLE: begin
                ps_nxt = '0;
                if (|req) begin
                    gid_nxt   = pick;
                    rem_nxt   = durs[pick];
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                ps_nxt = '0;
                if (!owner_req) begin
                    state_nxt = IDLE;
                    rem_nxt   = '0;
                    rr_nxt    = grant_id;
                end else if (remaining_us == '0) begin
                    state_nxt = DONE;
                end else begin
                    state_nxt = COUNT;
                end
            end
            COUNT: begin
                if (!owner_req) begin
                    state_nxt = IDLE;
                    rem_nxt   = '0;
                    rr_nxt    = grant_id;
                    ps_nxt    = '0;
                end else if (ps == PS_LAST) begin
                    ps_nxt  = '0;
                    rem_nxt = remaining_us - DUR_W'(1);
                    if (remaining_us == DUR_W'(1)) begin
                        state_nxt = DONE;
                    end
                end else begin
                    ps_nxt = ps + PS_W'(1);
                end
            end
            DONE: begin
                ps_nxt    = '0;
                rr_nxt    = grant_id;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset gives requester 0 first priority.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            rr_ptr       <= ID_W'(NUM_REQ - 1);
            grant_id     <= '0;
            ps           <= '0;
            remaining_us <= '0;
        end else begin
            state        <= state_nxt;
            rr_ptr       <= rr_nxt;
            grant_id     <= gid_nxt;
            ps           <= ps_nxt;
            remaining_us <= rem_nxt;
        end
    end

    // Outputs decode straight from registered state, so done is a clean one-cycle pulse.
    always_comb begin
        busy = (state != IDLE);
        for (int i = 0; i < NUM_REQ; i++) begin
            done[i] = (state == DONE) && (grant_id == ID_W'(i));
        end
    end

endmodule
